// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte-lane stores commit on acceptance,
// loads sample storage as the response is presented after a fixed latency.
module dmem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                    LATENCY     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int NB    = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic             req_err;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             accept;
    logic             do_write;
    logic             enter_resp;

    assign req_err = ({1'b0, req_addr} < BASE_EXT) ||
                     ({1'b0, req_addr} >= LIMIT_EXT) ||
                     (req_addr[1:0] != 2'b00);
    assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);

    assign accept     = req_valid && (state_q == IDLE) && !rst;
    assign do_write   = accept && req_wen && !req_err;
    assign enter_resp = (accept && (LATENCY == 1)) ||
                        ((state_q == WAIT) && (cnt_q == CNT_W'(1)));
    // With LATENCY==1 the read happens on the acceptance edge, before idx_q is loaded.
    assign rd_idx     = (state_q == WAIT) ? idx_q : req_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        err_d   = err_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d = req_wen;
                    err_d = req_err;
                    idx_d = req_idx;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Storage and its read register carry no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < NB; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
        if (enter_resp) begin
            rd_data_q <= mem_q[rd_idx];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = ((state_q == RESP) && !wen_q && !err_q) ? rd_data_q : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wstrb;

    logic        req_valid1, req_ready1, req_wen1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;
    logic [3:0]  req_wstrb1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    dmem_responder #(.LATENCY(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_wen    (req_wen1),
        .req_addr   (req_addr1),
        .req_wdata  (req_wdata1),
        .req_wstrb  (req_wstrb1),
        .resp_valid (resp_valid1),
        .resp_ready (resp_ready1),
        .resp_rdata (resp_rdata1),
        .resp_err   (resp_err1)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Called and returns on a falling edge. Checks the 2-cycle latency, a hold of
    // 'hold' extra cycles with stable outputs, and the return to IDLE on the handshake edge.
    task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int hold, input bit stray);
        chk({tag, " req_ready idle"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrb  = strb;
        resp_ready = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            chk($sformatf("%s resp_valid c%0d", tag, n), {31'b0, resp_valid}, (n == 2) ? 32'd1 : 32'd0);
        end
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        chk({tag, " req_ready busy"}, {31'b0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (stray && h == 0) begin
                req_valid = 1'b1;
                req_wen   = 1'b1;
                req_addr  = BASE;
                req_wdata = 32'h0;
                req_wstrb = 4'hF;
            end
            @(negedge clk);
            chk($sformatf("%s hold%0d valid", tag, h), {31'b0, resp_valid}, 32'd1);
            chk($sformatf("%s hold%0d rdata", tag, h), resp_rdata, exp_rd);
            chk($sformatf("%s hold%0d err", tag, h), {31'b0, resp_err}, {31'b0, exp_err});
            chk($sformatf("%s hold%0d req_ready", tag, h), {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " post-hs valid"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, " post-hs req_ready"}, {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        $display("TXN %-10s wen=%0d addr=%h wdata=%h strb=%h -> rdata=%h err=%0d", tag, wen, addr,
                 wdata, strb, exp_rd, exp_err);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        resp_ready  = 1'b0;
        req_valid1  = 1'b0;
        req_wen1    = 1'b0;
        req_addr1   = '0;
        req_wdata1  = '0;
        req_wstrb1  = '0;
        resp_ready1 = 1'b0;

        #2;
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        chk("rst err", {31'b0, resp_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        txn("st_beef", 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        txn("ld_beef", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        txn("st_strb5", 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 0, 1'b0);
        txn("ld_merge", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, 1'b0);

        txn("ld_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
        txn("ld_above", 1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
        txn("ld_misal", 1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
        txn("st_w0", 1'b1, BASE, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0, 1'b0);
        txn("st_above", 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0, 1'b0);
        txn("ld_w0", 1'b0, BASE, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

        txn("st_strb0", 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 0, 1'b0);
        txn("ld_strb0", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, 1'b0);

        // Stall the response; a request presented meanwhile must be ignored.
        txn("ld_hold", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 5, 1'b1);
        txn("ld_w0_2", 1'b0, BASE, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);

        resp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk($sformatf("idle rr%0d req_ready", n), {31'b0, req_ready}, 32'd1);
            chk($sformatf("idle rr%0d resp_valid", n), {31'b0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;

        // Asynchronous reset in WAIT of a load.
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = BASE + 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst ld resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst ld req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk($sformatf("arst ld no-resp%0d", n), {31'b0, resp_valid}, 32'd0);
        end
        txn("ld_postrst", 1'b0, BASE + 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 0, 1'b0);

        // Asynchronous reset in WAIT of a store: the write is already committed.
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = BASE + 32'h14;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst st resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst st req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst st no-resp", {31'b0, resp_valid}, 32'd0);
        txn("ld_commit", 1'b0, BASE + 32'h14, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0, 1'b0);

        // LATENCY=1 instance, back-to-back: stores then a load of the same word.
        chk("l1 req_ready start", {31'b0, req_ready1}, 32'd1);
        req_valid1  = 1'b1;
        resp_ready1 = 1'b1;
        req_wen1    = 1'b1;
        req_addr1   = BASE + 32'h8;
        req_wdata1  = 32'hDEAD_BEEF;
        req_wstrb1  = 4'hF;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk($sformatf("l1 c%0d resp_valid", n), {31'b0, resp_valid1}, (n % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("l1 c%0d req_ready", n), {31'b0, req_ready1}, (n % 2 == 0) ? 32'd1 : 32'd0);
            if (n % 2 == 1) begin
                chk($sformatf("l1 c%0d rdata", n), resp_rdata1, (n < 9) ? 32'h0 : 32'hDEAD_BEEF);
                chk($sformatf("l1 c%0d err", n), {31'b0, resp_err1}, 32'd0);
                $display("TXN l1_c%0d     wen=%0d addr=%h -> rdata=%h", n, req_wen1, req_addr1, resp_rdata1);
            end
            if (n == 8) req_wen1 = 1'b0;
        end
        req_valid1  = 1'b0;
        resp_ready1 = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: ADDR_WIDTH, default 32, request address width.
REQ-002 Parameter: DATA_WIDTH, default 32, data word width.
REQ-003 Parameter: DEPTH_WORDS, default 1024, number of storage words (power of two).
REQ-004 Parameter: BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-005 Parameter: LATENCY, default 2, number of cycles from request acceptance to response presentation (>=1).
REQ-006 Port: clk  input  1  the single clock; all state changes on rising edge.
REQ-007 Port: rst  input  1  reset, asynchronous, active-high.
REQ-008 Port: req_valid  input  1  initiator presents a request.
REQ-009 Port: req_ready  output  1  responder can accept a request.
REQ-010 Port: req_wen  input  1  1 = store, 0 = load.
REQ-011 Port: req_addr  input  ADDR_WIDTH  byte address.
REQ-012 Port: req_wdata  input  DATA_WIDTH  store data.
REQ-013 Port: req_wstrb  input  DATA_WIDTH/8  store byte-lane enables.
REQ-014 Port: resp_valid  output  1  response presented.
REQ-015 Port: resp_ready  input  1  initiator accepts the response.
REQ-016 Port: resp_rdata  output  DATA_WIDTH  load data; 0 for stores and errors.
REQ-017 Port: resp_err  output  1  request addressed outside storage or misaligned.

Function
REQ-018 The block SHALL implement the FSM states IDLE, WAIT and RESP, with at most one outstanding request.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_wen, req_addr, req_wdata and req_wstrb SHALL be captured on that edge.
REQ-021 On acceptance, the FSM SHALL go to WAIT and load the latency counter with LATENCY-1; if LATENCY==1, it SHALL go directly to RESP.
REQ-022 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-023 resp_valid SHALL assert exactly LATENCY cycles after the acceptance edge and SHALL be 1 only in RESP.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL remain stable until resp_valid && resp_ready, then the FSM SHALL return to IDLE on that edge.
REQ-025 A request SHALL be an error if addr < BASE_ADDR, if addr >= BASE_ADDR + 4*DEPTH_WORDS, or if addr[1:0] != 0.
REQ-026 The word index SHALL be (addr - BASE_ADDR) >> 2.
REQ-027 A store without error SHALL write, on the acceptance edge, each byte lane i whose req_wstrb[i]=1; all other lanes SHALL be unchanged.
REQ-028 An erroring store SHALL not modify storage.
REQ-029 A load without error SHALL sample storage on the edge entering RESP, so it reflects every store accepted earlier.
REQ-030 resp_rdata SHALL be 0 for stores and for errors.
REQ-031 resp_err SHALL be 1 in RESP for an erroring request and 0 otherwise.
REQ-032 req_valid asserted while req_ready=0 SHALL be ignored, with no capture and no state change.
REQ-033 resp_ready while not in RESP SHALL be ignored.
REQ-034 A store with req_wstrb=0 SHALL complete as a normal, non-error response with no storage change.

Reset
REQ-035 rst=1 SHALL immediately, without a clock edge, force the FSM to IDLE and the counter to 0.
REQ-036 While rst=1, outputs SHALL be req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-037 Reset mid-operation SHALL discard the pending response; a store already accepted SHALL remain committed.
REQ-038 Storage contents SHALL not be cleared by reset.
REQ-039 Requests SHALL be accepted from the first rising edge after rst deasserts.

Verification
REQ-040 Store 32'hDEAD_BEEF to 8000_0010 with wstrb 4'hF, then load 8000_0010 -> store response err=0 rdata=0; load response rdata=DEAD_BEEF err=0; each resp_valid exactly 2 cycles after acceptance.
REQ-041 Store 32'h1122_3344 with wstrb 4'b0101 over existing DEAD_BEEF, then load the same address -> rdata=DE22_BE44.
REQ-042 Load 7FFF_FFFC, load 8000_1000 and load 8000_0002 -> each gives resp_err=1, rdata=0; a store to 8000_1000 leaves storage unchanged (checked by a read of word 0).
REQ-043 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata/err stable and req_ready=0 throughout; IDLE follows the handshake edge.
REQ-044 Assert rst asynchronously while in WAIT of a load -> resp_valid=0 and req_ready=1 immediately; no response appears afterwards; a prior store is still readable.
REQ-045 LATENCY=1 build with back-to-back req_valid=1 and resp_ready=1 -> one acceptance every 2 cycles and resp_valid 1 cycle after each acceptance.
